// File: rtl/dsp48a1_mac_ctrl.sv
// Multiply-accumulate sequencer for a DSP48A1 slice: issues operand pairs,
// steers opmode through a tag line and returns one dot product per vector.
module dsp48a1_mac_ctrl #(
    parameter int PIPE_LAT = 3,
    parameter int OP_DLY   = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    input  logic             s_last,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [47:0]      r_data,
    output logic [CNT_W-1:0] r_count,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce_ab,
    output logic             dsp_ce_mp,
    output logic             dsp_rst_p,
    input  logic [47:0]      dsp_p
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DW = $clog2(PIPE_LAT + 1);

    state_t          state_q, state_d;
    logic [DW-1:0]   drain_q;
    logic [1:0]      tag_q [0:OP_DLY];
    logic            fresh_q;
    logic [47:0]     r_data_q;
    logic            hs;
    logic            first_hs;

    assign hs       = s_valid & s_ready;
    assign first_hs = hs & (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = s_last ? DRAIN : RUN;
            RUN:     if (hs && s_last) state_d = DRAIN;
            DRAIN:   if (drain_q == DW'(PIPE_LAT - 1)) state_d = DONE;
            DONE:    if (r_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready   = ~rst & ((state_q == IDLE) | (state_q == RUN));
        r_valid   = ~rst & (state_q == DONE);
        dsp_ce_mp = ~rst & ((state_q == RUN) | (state_q == DRAIN));
        dsp_rst_p = rst;
        case (tag_q[OP_DLY])
            2'b11:   dsp_opmode = 8'h01;
            2'b10:   dsp_opmode = 8'h09;
            default: dsp_opmode = 8'h08;
        endcase
        // P only settles on the edge that enters DONE, so the first DONE
        // cycle forwards it directly; the register holds it from then on.
        r_data = fresh_q ? dsp_p : r_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dsp_a     <= '0;
            dsp_b     <= '0;
            dsp_ce_ab <= 1'b0;
            r_count   <= '0;
            drain_q   <= '0;
            fresh_q   <= 1'b0;
            r_data_q  <= '0;
            for (int unsigned i = 0; i <= OP_DLY; i++) tag_q[i] <= '0;
        end else begin
            dsp_ce_ab <= hs;
            if (hs) begin
                dsp_a <= s_a;
                dsp_b <= s_b;
                if (first_hs)     r_count <= CNT_W'(1);
                else if (~&r_count) r_count <= r_count + 1'b1;
            end
            tag_q[0] <= {hs, first_hs};
            for (int unsigned i = 1; i <= OP_DLY; i++) tag_q[i] <= tag_q[i-1];
            drain_q <= (state_q == DRAIN) ? drain_q + 1'b1 : '0;
            fresh_q <= (state_q == DRAIN) && (state_d == DONE);
            if (fresh_q) r_data_q <= dsp_p;
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// Directed bench for dsp48a1_mac_ctrl with a behavioural DSP48A1 slice
// (A1/B1, M, opmode and P registers) closing the loop on dsp_p.
module tb_dsp48a1_mac_ctrl;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_a;
    logic [17:0] s_b;
    logic        s_last;
    logic        r_valid;
    logic        r_ready;
    logic [47:0] r_data;
    logic [15:0] r_count;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce_ab;
    logic        dsp_ce_mp;
    logic        dsp_rst_p;
    logic [47:0] dsp_p;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] opm_hist [0:4095];

    dsp48a1_mac_ctrl #(.PIPE_LAT(3), .OP_DLY(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_count(r_count),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
        .dsp_ce_ab(dsp_ce_ab), .dsp_ce_mp(dsp_ce_mp), .dsp_rst_p(dsp_rst_p),
        .dsp_p(dsp_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice model: X = M when opmode[1:0]=01, Z = P when opmode[3:2]=10.
    logic signed [17:0] a1 = '0;
    logic signed [17:0] b1 = '0;
    logic [47:0] m_reg = '0;
    logic [7:0]  opm_reg = 8'h08;
    logic [47:0] p_reg = '0;
    logic signed [35:0] prod;
    assign prod  = a1 * b1;
    assign dsp_p = p_reg;

    always @(posedge clk) begin
        if (dsp_ce_ab) begin
            a1 <= dsp_a;
            b1 <= dsp_b;
        end
        if (dsp_ce_mp) begin
            m_reg   <= {{12{prod[35]}}, prod};
            opm_reg <= dsp_opmode;
        end
        if (dsp_rst_p)
            p_reg <= '0;
        else if (dsp_ce_mp)
            p_reg <= ((opm_reg[1:0] == 2'b01) ? m_reg : 48'd0)
                   + ((opm_reg[3:2] == 2'b10) ? p_reg : 48'd0);
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 4096) opm_hist[cyc] <= dsp_opmode;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [17:0] a, input logic [17:0] b, input logic last,
                        output int hs);
        hs = -1;
        s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_ready) begin
                hs = cyc;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        total++;
        if (hs < 0) begin
            bad++;
            $display("FAIL push_timeout: s_ready never seen, got=0 want=1");
        end
    endtask

    task automatic wait_result(output int rc);
        rc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r_valid) begin
                rc = cyc;
                break;
            end
        end
    endtask

    task automatic consume();
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        total += 10;
        if (s_ready !== 1'b0)       begin bad++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
        if (r_valid !== 1'b0)       begin bad++; $display("FAIL rst_r_valid got=%b want=0", r_valid); end
        if (r_data !== 48'd0)       begin bad++; $display("FAIL rst_r_data got=%h want=0", r_data); end
        if (r_count !== 16'd0)      begin bad++; $display("FAIL rst_r_count got=%0d want=0", r_count); end
        if (dsp_a !== 18'd0)        begin bad++; $display("FAIL rst_dsp_a got=%h want=0", dsp_a); end
        if (dsp_b !== 18'd0)        begin bad++; $display("FAIL rst_dsp_b got=%h want=0", dsp_b); end
        if (dsp_opmode !== 8'h08)   begin bad++; $display("FAIL rst_opmode got=%h want=08", dsp_opmode); end
        if (dsp_ce_ab !== 1'b0)     begin bad++; $display("FAIL rst_ce_ab got=%b want=0", dsp_ce_ab); end
        if (dsp_ce_mp !== 1'b0)     begin bad++; $display("FAIL rst_ce_mp got=%b want=0", dsp_ce_mp); end
        if (dsp_rst_p !== 1'b1)     begin bad++; $display("FAIL rst_rst_p got=%b want=1", dsp_rst_p); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total += 2;
        if (s_ready !== 1'b1)   begin bad++; $display("FAIL post_rst_s_ready got=%b want=1", s_ready); end
        if (dsp_rst_p !== 1'b0) begin bad++; $display("FAIL post_rst_rst_p got=%b want=0", dsp_rst_p); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int h0, h1, h2, rc;
        push(18'd1, 18'd4, 1'b0, h0);
        push(18'd2, 18'd5, 1'b0, h1);
        push(18'd3, 18'd6, 1'b1, h2);
        wait_result(rc);
        total += 7;
        if (rc - h2 !== 4)            begin bad++; $display("FAIL basic_latency got=%0d want=4", rc - h2); end
        if (r_data !== 48'd32)        begin bad++; $display("FAIL basic_data got=%0d want=32", r_data); end
        if (r_count !== 16'd3)        begin bad++; $display("FAIL basic_count got=%0d want=3", r_count); end
        if (h2 - h0 !== 2)            begin bad++; $display("FAIL basic_b2b got=%0d want=2", h2 - h0); end
        if (opm_hist[h0+2] !== 8'h01) begin bad++; $display("FAIL basic_opm0 got=%h want=01", opm_hist[h0+2]); end
        if (opm_hist[h0+3] !== 8'h09) begin bad++; $display("FAIL basic_opm1 got=%h want=09", opm_hist[h0+3]); end
        if (opm_hist[h0+4] !== 8'h09) begin bad++; $display("FAIL basic_opm2 got=%h want=09", opm_hist[h0+4]); end
        consume();
        @(negedge clk);
        total += 2;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL basic_gap_s_ready got=%b want=1", s_ready); end
        if (r_valid !== 1'b0) begin bad++; $display("FAIL basic_gap_r_valid got=%b want=0", r_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int h0, rc;
        push(-18'sd3, 18'd7, 1'b1, h0);
        wait_result(rc);
        total += 3;
        if (rc - h0 !== 4)                 begin bad++; $display("FAIL single_latency got=%0d want=4", rc - h0); end
        if (r_data !== 48'hFFFF_FFFF_FFEB) begin bad++; $display("FAIL single_data got=%h want=ffffffffffeb", r_data); end
        if (r_count !== 16'd1)             begin bad++; $display("FAIL single_count got=%0d want=1", r_count); end
        consume();
    endtask

    task automatic test_bubbles();
        int h0, h1, h2, rc;
        push(18'd1, 18'd4, 1'b0, h0);
        @(posedge clk); #1;
        push(18'd2, 18'd5, 1'b0, h1);
        @(posedge clk); #1;
        push(18'd3, 18'd6, 1'b1, h2);
        wait_result(rc);
        total += 9;
        if (r_data !== 48'd32)        begin bad++; $display("FAIL bubble_data got=%0d want=32", r_data); end
        if (r_count !== 16'd3)        begin bad++; $display("FAIL bubble_count got=%0d want=3", r_count); end
        if (h2 - h0 !== 4)            begin bad++; $display("FAIL bubble_spacing got=%0d want=4", h2 - h0); end
        if (opm_hist[h0+2] !== 8'h01) begin bad++; $display("FAIL bubble_opm0 got=%h want=01", opm_hist[h0+2]); end
        if (opm_hist[h0+3] !== 8'h08) begin bad++; $display("FAIL bubble_opm1 got=%h want=08", opm_hist[h0+3]); end
        if (opm_hist[h0+4] !== 8'h09) begin bad++; $display("FAIL bubble_opm2 got=%h want=09", opm_hist[h0+4]); end
        if (opm_hist[h0+5] !== 8'h08) begin bad++; $display("FAIL bubble_opm3 got=%h want=08", opm_hist[h0+5]); end
        if (opm_hist[h0+6] !== 8'h09) begin bad++; $display("FAIL bubble_opm4 got=%h want=09", opm_hist[h0+6]); end
        if (opm_hist[h0+7] !== 8'h08) begin bad++; $display("FAIL bubble_opm5 got=%h want=08", opm_hist[h0+7]); end
        consume();
    endtask

    task automatic test_hold_then_next();
        int h, rc;
        push(18'd1, 18'd4, 1'b0, h);
        push(18'd2, 18'd5, 1'b0, h);
        push(18'd3, 18'd6, 1'b1, h);
        wait_result(rc);
        total++;
        if (rc < 0) begin bad++; $display("FAIL hold_no_result got=none want=r_valid"); end
        s_valid = 1'b1; s_a = 18'd99; s_b = 18'd99; s_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total += 3;
            if (r_valid !== 1'b1)  begin bad++; $display("FAIL hold_r_valid[%0d] got=%b want=1", i, r_valid); end
            if (r_data !== 48'd32) begin bad++; $display("FAIL hold_r_data[%0d] got=%0d want=32", i, r_data); end
            if (s_ready !== 1'b0)  begin bad++; $display("FAIL hold_s_ready[%0d] got=%b want=0", i, s_ready); end
        end
        s_valid = 1'b0; s_last = 1'b0;
        consume();
        push(18'd2, 18'd2, 1'b1, h);
        wait_result(rc);
        total += 2;
        if (r_data !== 48'd4)  begin bad++; $display("FAIL next_data got=%0d want=4", r_data); end
        if (r_count !== 16'd1) begin bad++; $display("FAIL next_count got=%0d want=1", r_count); end
        consume();
    endtask

    task automatic test_same_cycle_consume();
        int h, rc;
        r_ready = 1'b1;
        push(18'd2, 18'd3, 1'b1, h);
        wait_result(rc);
        total++;
        if (r_data !== 48'd6) begin bad++; $display("FAIL same_data got=%0d want=6", r_data); end
        @(negedge clk);
        total += 2;
        if (r_valid !== 1'b0) begin bad++; $display("FAIL same_r_valid got=%b want=0", r_valid); end
        if (s_ready !== 1'b1) begin bad++; $display("FAIL same_s_ready got=%b want=1", s_ready); end
        @(posedge clk); #1;
        r_ready = 1'b0;
    endtask

    task automatic test_max_operands();
        int h, rc;
        push(18'd131071, 18'd131071, 1'b0, h);
        push(18'd131071, 18'd131071, 1'b1, h);
        wait_result(rc);
        total += 2;
        if (r_data !== 48'd34359214082) begin bad++; $display("FAIL max_data got=%0d want=34359214082", r_data); end
        if (r_count !== 16'd2)          begin bad++; $display("FAIL max_count got=%0d want=2", r_count); end
        consume();
    endtask

    task automatic test_reset_mid_vector();
        int h, rc, seen;
        push(18'd1, 18'd1, 1'b0, h);
        push(18'd2, 18'd2, 1'b0, h);
        rst = 1'b1;
        s_valid = 1'b1; s_a = 18'd3; s_b = 18'd3; s_last = 1'b0;
        @(negedge clk);
        total += 2;
        if (s_ready !== 1'b0)   begin bad++; $display("FAIL midrst_s_ready got=%b want=0", s_ready); end
        if (dsp_rst_p !== 1'b1) begin bad++; $display("FAIL midrst_rst_p got=%b want=1", dsp_rst_p); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (r_valid) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL midrst_abandon got=%0d want=0 r_valid cycles", seen); end
        @(posedge clk); #1;
        push(18'd5, 18'd5, 1'b1, h);
        wait_result(rc);
        total += 2;
        if (r_data !== 48'd25) begin bad++; $display("FAIL midrst_next_data got=%0d want=25", r_data); end
        if (r_count !== 16'd1) begin bad++; $display("FAIL midrst_next_count got=%0d want=1", r_count); end
        consume();
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; r_ready = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_bubbles();
        test_hold_then_next();
        test_same_cycle_consume();
        test_max_operands();
        test_reset_mid_vector();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp48a1_mac_ctrl.md
# dsp48a1_mac_ctrl

Sequencer that drives the DSP48A1 slice as a multiply-accumulate engine. It accepts a valid/ready stream of signed 18-bit operand pairs grouped into vectors by a `last` flag, and drives the slice's A/B operands, opmode and clock enables. It tracks the slice pipeline latency and returns one 48-bit dot-product result per vector on a valid/ready result port. It is the initiator side of the slice's operand/opmode interface and sits between a sample source and the arithmetic slice.

## Interface
- `PIPE_LAT`, 3, cycles from `dsp_a`/`dsp_b` presentation to the corresponding `dsp_p` value (A1/B1 reg, M reg, P reg).
- `OP_DLY`, 1, cycles by which a sample's opmode trails its operands on `dsp_a`/`dsp_b`.
- `CNT_W`, 16, width of the per-vector sample counter.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  operand pair valid.
- `s_ready`  out  1  controller accepts the pair this cycle.
- `s_a`  in  18  signed multiplicand.
- `s_b`  in  18  signed multiplier.
- `s_last`  in  1  final pair of the current vector.
- `r_valid`  out  1  result valid.
- `r_ready`  in  1  result consumed.
- `r_data`  out  48  signed accumulated sum.
- `r_count`  out  CNT_W  number of pairs in the vector.
- `dsp_a`, `dsp_b`  out  18  operands to slice.
- `dsp_opmode`  out  8  opmode to slice.
- `dsp_ce_ab`  out  1  CE for slice A/B registers.
- `dsp_ce_mp`  out  1  CE for slice M/P/opmode registers.
- `dsp_rst_p`  out  1  reset for slice P register.
- `dsp_p`  in  48  slice P output.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `s_ready`=1. A handshake (`s_valid & s_ready`) starts the vector with its first pair and enters RUN, or enters DRAIN if `s_last`=1.
- RUN: `s_ready`=1. Each handshake issues one pair. A handshake with `s_last`=1 enters DRAIN.
- DRAIN: `s_ready`=0. A counter runs PIPE_LAT cycles from the last issue, then `dsp_p` is captured into `r_data` and the state moves to DONE.
- DONE: `s_ready`=0, `r_valid`=1. `r_data`/`r_count` are held stable until `r_ready`=1, then the state returns to IDLE.
- Issue: `dsp_a`<=`s_a`, `dsp_b`<=`s_b` registered, with `dsp_ce_ab`=1 in that cycle only. `dsp_ce_ab`=0 otherwise, so the operands hold.
- Tag line of depth OP_DLY carries {valid, first} per cycle. `dsp_opmode` is derived from the tag at the output of the line:
  - valid&first → 8'h01 (X=M, Z=0; start fresh).
  - valid&~first → 8'h09 (X=M, Z=P; accumulate).
  - ~valid (bubble) → 8'h08 (X=0, Z=P; hold).
- Bubbles when `s_valid`=0 in RUN never change the sum.
- `dsp_ce_mp`=1 in RUN and DRAIN, and 0 in IDLE/DONE.
- `r_count` increments on each handshake and is cleared on the first pair of a vector. It saturates at all-ones.
- Arithmetic: 18x18 signed product is sign-extended to 48 bits. Wrap-around is modulo 2^48 with no overflow flag.

## Timing
- Reset values: state IDLE, `s_ready`=0 during `rst`, `r_valid`=0, `r_data`=0, `r_count`=0, `dsp_a`=`dsp_b`=0, `dsp_opmode`=8'h08, `dsp_ce_ab`=`dsp_ce_mp`=0, `dsp_rst_p`=1 while `rst`=1.
- `s_ready`=1 the first cycle after `rst` deasserts.
- Last pair accepted at cycle t → `r_valid` rises at t+PIPE_LAT+1.
- Minimum vector-to-vector gap: one cycle after the `r_ready` handshake.
- `r_valid` and `r_ready` in the same cycle as DONE entry: consumed that cycle, IDLE next.
- `rst` mid-RUN/DRAIN/DONE: the vector is abandoned with no `r_valid`. The slice P register is cleared via `dsp_rst_p`, and the tag line is flushed to bubbles.
- `s_valid` is ignored whenever `s_ready`=0. Pairs are not buffered.

## Test plan
- Vector a=[1,2,3], b=[4,5,6], back-to-back valid → `r_data`=32, `r_count`=3, `r_valid` exactly PIPE_LAT+1 cycles after the last handshake.
- Single-pair vector a=-3, b=7 with `s_last`=1 → `r_data`=48'hFFFF_FFFF_FFEB, `r_count`=1.
- Same vector as the first test with `s_valid` low every other cycle → `r_data`=32, `dsp_opmode`=8'h08 in bubble slots.
- `r_ready` held low 5 cycles in DONE → `r_valid`/`r_data` stable and `s_ready`=0 throughout. Then a second vector a=[2], b=[2] → `r_data`=4, with no carry-over from 32.
- a=[131071,131071], b=[131071,131071] → `r_data`=2*(131071²)=34359214082.
- Assert `rst` two cycles after a 4-pair vector starts → no `r_valid`. The next vector a=[5], b=[5] → `r_data`=25.
